hsm_axil_regfile: RTL and testbench
===================================

Name: hsm_axil_regfile

Overview:
Parametrised AXI4-Lite slave register file for the HSM core, replacing the fixed 4-register bus wrapper.
- NUM_REGS registers, each either bus-writable control (RW) or core-driven status (RO).
- Independent AW/W acceptance, byte strobes, SLVERR on illegal access.
- Per-register access pulses to the core.
- Sits between the PS AXI interconnect and the HSM datapath/FSM.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width; 32 only (checked at elaboration).
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2^(C_S_AXI_ADDR_WIDTH-2) >= NUM_REGS.
NUM_REGS, 16, number of 32-bit registers (2..64).
RO_MASK, 16'h0002, bit i=1: reg i is read-only from the bus and its value comes from reg_in.
W1C_MASK, 16'h0000, bit i=1: reg i is write-1-to-clear (only with HSM_REGFILE_W1C_EN).
RESET_VAL, 0, reset value of every RW register.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR/3/1/1  write address channel; PROT ignored
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR/3/1/1  read address; PROT ignored
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data
reg_out  out  NUM_REGS*32  current value of every register; reg i at [32i+:32]
reg_in  in  NUM_REGS*32  core values for RO registers; other slices unused
wr_pulse  out  NUM_REGS  one-cycle strobe on write commit to reg i
rd_pulse  out  NUM_REGS  one-cycle strobe on AR handshake for reg i
hw_set  in  NUM_REGS  core set bits for W1C registers (ORed into bit 0 upward, full word: hw_set[i] sets bit 0 of reg i)

Behaviour:
- Interface (already decided): one clock S_AXI_ACLK; reset S_AXI_ARESETN is asynchronous and active-low.
- Reset values:
  - All AXI outputs are 0.
  - RW registers take RESET_VAL.
  - wr_pulse and rd_pulse are 0.
  - Skid holding registers are empty.
- Address decode: index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]; bits [1:0] ignored.
- AW and W are each captured into their own one-entry holding register (aw_full, w_full).
  - AWREADY = !aw_full; WREADY = !w_full. Both are registered and go to 1 on the first clock after reset release.
  - AW and W may arrive in either order or in the same cycle.
- Write commit happens in the cycle when aw_full && w_full && (!BVALID || BREADY). On commit:
  - Index < NUM_REGS and RO_MASK[i]=0: per-byte update where WSTRB[b]=1; BRESP=OKAY; wr_pulse[i]=1 for one cycle.
  - Index >= NUM_REGS, or RO register: no state change, no wr_pulse, BRESP=SLVERR (2'b10).
  - BVALID goes to 1 next cycle and holds until BREADY; both holding registers clear.
- Throughput: one write per 2 cycles minimum.
- A new AW/W may be captured while BVALID is pending; commit stalls until the B handshake.
- Read path:
  - ARREADY = !RVALID || RREADY (gated 0 in reset).
  - On the AR handshake, RDATA/RRESP are registered and RVALID=1 on the next cycle (latency 1).
  - Sustains one read per cycle when RREADY is held high.
  - RVALID, RDATA and RRESP are held stable until RREADY.
- Read data:
  - RO registers return reg_in slice sampled at the AR handshake.
  - Out-of-range index returns RDATA=0, RRESP=SLVERR, and no rd_pulse.
- Read and write committing to the same register in the same cycle: read returns the pre-write value.
- Reset asserted mid-transaction: all channels abort immediately and outputs return to reset values; no partial writes.

Optional Feature:
HSM_REGFILE_W1C_EN
- Defined: registers with W1C_MASK[i]=1 are status-sticky.
  - hw_set[i]=1 sets bit 0.
  - A bus write clears each bit where WDATA=1 and the corresponding strobe byte is enabled.
  - If hw_set and a clear occur in the same cycle, set wins.
  - Reset value is 0.
- Undefined: W1C_MASK is ignored, hw_set is ignored, and those registers behave as plain RW.

Decomposition:
- Package hsm_regfile_pkg:
  - resp_t (2-bit) with RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - REG_BYTES=4.
  - Function addr_to_idx.
  - Function apply_wstrb(old, data, strb).
- Sub-module hsm_axil_skid: one-entry valid/ready holding register (payload width parameter), instantiated twice (AW and W).

Test Plan:
1. Reset release, write 0xDEADBEEF to 0x08 with WSTRB=4'hF, AW and W in the same cycle -> BRESP=OKAY, wr_pulse[2] for one cycle; read 0x08 -> RDATA=0xDEADBEEF after 1 cycle.
2. W presented 3 cycles before AW, WSTRB=4'b0010, data 0x0000AB00 to reg 0 holding 0x11223344 -> reg 0 = 0x1122AB44.
3. Write to 0x04 (RO) and to 0x3C with NUM_REGS=8 -> BRESP=SLVERR and registers unchanged; read 0x3C -> RDATA=0, RRESP=SLVERR.
4. BREADY held low 5 cycles while a second AW/W is issued -> second write captured but not committed until the first B handshake; two B responses in order.
5. Back-to-back ARs on 0x00, 0x04, 0x08 with RREADY=1 -> one RVALID per cycle; the 0x04 read returns reg_in slice 1; then RREADY low -> RDATA stable and ARREADY=0.
6. With HSM_REGFILE_W1C_EN and W1C_MASK bit 3: hw_set[3] pulse -> reg 3 = 1; write 0x1 while hw_set[3]=1 -> reg 3 stays 1; write 0x1 alone -> reg 3 = 0.

Source files
------------

// File: rtl/hsm_regfile_pkg.sv
// hsm_regfile_pkg: shared types and helpers for the HSM AXI4-Lite register file.
// Word-oriented helpers assume 32-bit registers (REG_BYTES bytes each).
package hsm_regfile_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  localparam int unsigned REG_BYTES = 4;
  localparam int unsigned REG_BITS  = REG_BYTES * 8;

  // Word index from a byte address: keep the low addr_width bits, drop the byte offset.
  function automatic logic [31:0] addr_to_idx(input logic [31:0] addr,
                                              input int unsigned addr_width);
    logic [31:0] keep;
    keep = (32'd1 << addr_width) - 32'd1;
    return (addr & keep) >> 2;
  endfunction

  // Expand a byte strobe into a bit mask.
  function automatic logic [REG_BITS-1:0] strb_mask(input logic [REG_BYTES-1:0] strb);
    logic [REG_BITS-1:0] m;
    for (int b = 0; b < REG_BYTES; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

  // Byte-merge new data into an old word under a strobe.
  function automatic logic [REG_BITS-1:0] apply_wstrb(input logic [REG_BITS-1:0]  old,
                                                      input logic [REG_BITS-1:0]  data,
                                                      input logic [REG_BYTES-1:0] strb);
    logic [REG_BITS-1:0] m;
    m = strb_mask(strb);
    return (old & ~m) | (data & m);
  endfunction

endpackage

// File: rtl/hsm_axil_skid.sv
// hsm_axil_skid: one-entry valid/ready holding register for an AXI4-Lite
// request channel. in_ready is registered (= !full) and low during reset.
module hsm_axil_skid #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             full,
  output logic [WIDTH-1:0] data,
  input  logic             pop
);

  logic             full_q, full_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next state: pop empties the slot, a handshake fills it; ready tracks emptiness.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    full_d = full_q;
    data_d = data_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (in_valid && ready_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
    ready_d = !full_d;
  end

  // Slot state; ready rises on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops use non-blocking assignment so each one samples the pre-edge value of the others.
    if (!rst_n) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign in_ready = ready_q;
  assign full     = full_q;
  assign data     = data_q;

endmodule

// File: rtl/hsm_axil_regfile.sv
// hsm_axil_regfile: parametrised AXI4-Lite slave register file for the HSM core.
// RW registers are bus-written with byte strobes; RO registers mirror reg_in.
// Optional macro HSM_REGFILE_W1C_EN turns W1C_MASK registers into sticky status
// bits (hw_set sets bit 0, bus write-1 clears, set wins on collision).
module hsm_axil_regfile
  import hsm_regfile_pkg::*;
#(
  parameter int                     C_S_AXI_DATA_WIDTH = 32,
  parameter int                     C_S_AXI_ADDR_WIDTH = 6,
  parameter int                     NUM_REGS           = 16,
  parameter logic [NUM_REGS-1:0]    RO_MASK            = 16'h0002,
  parameter logic [NUM_REGS-1:0]    W1C_MASK           = 16'h0000,
  parameter logic [31:0]            RESET_VAL          = 32'h0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]          reg_out,
  input  logic [NUM_REGS*32-1:0]          reg_in,
  output logic [NUM_REGS-1:0]             wr_pulse,
  output logic [NUM_REGS-1:0]             rd_pulse,
  input  logic [NUM_REGS-1:0]             hw_set
);

`ifdef HSM_REGFILE_W1C_EN
  localparam bit W1C_ON = 1'b1;
`else
  localparam bit W1C_ON = 1'b0;
`endif

  // Elaboration-time parameter sanity.
  if (C_S_AXI_DATA_WIDTH != 32) begin : g_chk_dw
    $error("hsm_axil_regfile: C_S_AXI_DATA_WIDTH must be 32");
  end
  if (NUM_REGS < 2 || NUM_REGS > 64) begin : g_chk_nr
    $error("hsm_axil_regfile: NUM_REGS must be 2..64");
  end
  if ((64'd1 << (C_S_AXI_ADDR_WIDTH - 2)) < 64'(NUM_REGS)) begin : g_chk_aw
    $error("hsm_axil_regfile: address width too small for NUM_REGS");
  end

  // Write channel holding registers.
  logic                          aw_full, w_full, commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [REG_BITS+REG_BYTES-1:0] w_payload;
  logic [REG_BITS-1:0]           w_data;
  logic [REG_BYTES-1:0]          w_strb;

  hsm_axil_skid #(.WIDTH(C_S_AXI_ADDR_WIDTH)) u_aw_skid (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .in_valid (S_AXI_AWVALID),
    .in_ready (S_AXI_AWREADY),
    .in_data  (S_AXI_AWADDR),
    .full     (aw_full),
    .data     (aw_addr),
    .pop      (commit)
  );

  hsm_axil_skid #(.WIDTH(REG_BITS + REG_BYTES)) u_w_skid (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .in_valid (S_AXI_WVALID),
    .in_ready (S_AXI_WREADY),
    .in_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
    .full     (w_full),
    .data     (w_payload),
    .pop      (commit)
  );

  assign w_data = w_payload[REG_BITS-1:0];
  assign w_strb = w_payload[REG_BITS +: REG_BYTES];

  // Address decode for the held write address and the live read address.
  logic [31:0]         aw_idx, ar_idx;
  logic [NUM_REGS-1:0] aw_sel, ar_sel;

  // One-hot register select per channel; out-of-range indices select nothing.
  always_comb begin
    aw_idx = addr_to_idx(32'(aw_addr), C_S_AXI_ADDR_WIDTH);
    ar_idx = addr_to_idx(32'(S_AXI_ARADDR), C_S_AXI_ADDR_WIDTH);
    for (int i = 0; i < NUM_REGS; i++) begin
      aw_sel[i] = (aw_idx == 32'(i));
      ar_sel[i] = (ar_idx == 32'(i));
    end
  end

  // Commit needs both halves held and the B slot free (or being freed this cycle).
  logic aw_legal, wr_ok;
  assign commit   = aw_full && w_full && (!S_AXI_BVALID || S_AXI_BREADY);
  assign aw_legal = |(aw_sel & ~RO_MASK);
  assign wr_ok    = commit && aw_legal;

  // Register storage: RO slots mirror reg_in, RW slots are flops.
  logic [NUM_REGS-1:0][REG_BITS-1:0] cur_val;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign cur_val[gi] = reg_in[32*gi +: 32];
    end else begin : g_rw
      localparam bit          IS_W1C  = W1C_ON && W1C_MASK[gi];
      localparam logic [31:0] RST_VAL = IS_W1C ? 32'h0 : RESET_VAL;
      logic [REG_BITS-1:0] val_q, val_d;
      logic                hit;

      assign hit = wr_ok && aw_sel[gi];

      // Next value: W1C clears then hw_set (set wins), otherwise a strobed byte merge.
      always_comb begin
        val_d = val_q;
        if (IS_W1C) begin
          if (hit) begin
            val_d = val_q & ~(w_data & strb_mask(w_strb));
          end
          if (hw_set[gi]) begin
            val_d[0] = 1'b1;
          end
        end else if (hit) begin
          val_d = apply_wstrb(val_q, w_data, w_strb);
        end
      end

      // Register flop with reset value.
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        // NOTE: this is a bank of individual flops, not an inferred RAM, so every entry is reset.
        if (!S_AXI_ARESETN) begin
          val_q <= RST_VAL;
        end else begin
          val_q <= val_d;
        end
      end

      assign cur_val[gi] = val_q;
    end
  end

  assign reg_out = cur_val;

  // Write response and write strobes.
  resp_t               bresp_q, bresp_d;
  logic                bvalid_q, bvalid_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  // B channel: raise on commit, drop on handshake; pulse the written register once.
  always_comb begin
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = wr_ok ? aw_sel : '0;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = aw_legal ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Read channel state.
  logic                arready_en_q, arready_en_d;
  logic                rvalid_q, rvalid_d;
  logic [REG_BITS-1:0] rdata_q, rdata_d, rd_word;
  resp_t               rresp_q, rresp_d;
  logic [NUM_REGS-1:0] rd_pulse_q, rd_pulse_d;
  logic                ar_hs;

  assign S_AXI_ARREADY = arready_en_q && (!rvalid_q || S_AXI_RREADY);
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

  // R channel: capture the pre-write register value at the AR handshake and hold until RREADY.
  always_comb begin
    arready_en_d = 1'b1;
    rd_word      = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_sel[i]) begin
        rd_word = rd_word | cur_val[i];
      end
    end
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_pulse_d = '0;
    if (ar_hs) begin
      rvalid_d   = 1'b1;
      rdata_d    = rd_word;
      rresp_d    = (|ar_sel) ? RESP_OKAY : RESP_SLVERR;
      rd_pulse_d = ar_sel;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // Response-side flops; all clear immediately on reset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      wr_pulse_q   <= '0;
      arready_en_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      rd_pulse_q   <= '0;
    end else begin
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      wr_pulse_q   <= wr_pulse_d;
      arready_en_q <= arready_en_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rd_pulse_q   <= rd_pulse_d;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign wr_pulse     = wr_pulse_q;
  assign rd_pulse     = rd_pulse_q;

  // PROT is ignored; reg_in slices of RW registers and hw_set (without W1C) are don't-care.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, reg_in, hw_set};

endmodule

// File: tb/tb_hsm_axil_regfile.sv
// tb_hsm_axil_regfile: directed self-checking bench for hsm_axil_regfile
// (NUM_REGS=8, reg 1 read-only, reg 3 in W1C_MASK). Inputs change 1 ns after
// the rising edge; outputs are sampled at that same point.
module tb_hsm_axil_regfile;
  import hsm_regfile_pkg::*;

  localparam int NR = 8;
  localparam int AW = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   awaddr = '0, araddr = '0;
  logic [2:0]      awprot = '0, arprot = '0;
  logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic            arvalid = 1'b0, rready = 1'b0;
  logic [31:0]     wdata = '0;
  logic [3:0]      wstrb = '0;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [1:0]      bresp, rresp;
  logic [31:0]     rdata;
  logic [NR*32-1:0] reg_out, reg_in;
  logic [NR-1:0]   wr_pulse, rd_pulse;
  logic [NR-1:0]   hw_set = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hsm_axil_regfile #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (AW),
    .NUM_REGS           (NR),
    .RO_MASK            (8'h02),
    .W1C_MASK           (8'h08),
    .RESET_VAL          (32'h0)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .reg_in        (reg_in),
    .wr_pulse      (wr_pulse),
    .rd_pulse      (rd_pulse),
    .hw_set        (hw_set)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rv(input int i);
    return reg_out[32*i +: 32];
  endfunction

  task automatic send_aw(input logic [AW-1:0] a);
    int n = 0;
    awaddr  = a;
    awvalid = 1'b1;
    while (!awready && n < 50) begin
      tick();
      n++;
    end
    check("awready_wait", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    while (!wready && n < 50) begin
      tick();
      n++;
    end
    check("wready_wait", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output logic [NR-1:0] p_at,
                        output logic [NR-1:0] p_after);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin
      tick();
      n++;
    end
    check("bvalid_wait", 32'(bvalid), 32'd1);
    resp = bresp;
    p_at = wr_pulse;
    tick();
    bready  = 1'b0;
    p_after = wr_pulse;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [NR-1:0] p_at,
                          output logic [NR-1:0] p_after);
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b(resp, p_at, p_after);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r,
                         output logic [NR-1:0] p, output int lat);
    int n = 0;
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    #1;
    while (!arready && n < 50) begin
      tick();
      n++;
    end
    check("arready_wait", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
    d = rdata;
    r = rresp;
    p = rd_pulse;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]    resp, r;
    logic [NR-1:0] p_at, p_after, p;
    logic [31:0]   d;
    logic [31:0]   exp_regs [NR];
    int            lat;

    for (int i = 0; i < NR; i++) begin
      reg_in[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
    end
    reg_in[63:32] = 32'hCAFE_0001;

    // Reset state
    repeat (3) tick();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_pulses", 32'({wr_pulse, rd_pulse}), 32'd0);
    check("rst_reg0", rv(0), 32'h0);
    check("rst_reg1_ro", rv(1), 32'hCAFE_0001);
    check("rst_reg7", rv(7), 32'h0);
    rst_n = 1'b1;
    tick();
    check("rel_awready", 32'(awready), 32'd1);
    check("rel_wready", 32'(wready), 32'd1);
    check("rel_arready", 32'(arready), 32'd1);

    // 1: full-word write with AW and W together, then read back
    do_write(6'h08, 32'hDEAD_BEEF, 4'hF, resp, p_at, p_after);
    check("t1_bresp", 32'(resp), 32'(RESP_OKAY));
    check("t1_wr_pulse", 32'(p_at), 32'h04);
    check("t1_wr_pulse_once", 32'(p_after), 32'h00);
    check("t1_reg2", rv(2), 32'hDEAD_BEEF);
    do_read(6'h08, d, r, p, lat);
    check("t1_rdata", d, 32'hDEAD_BEEF);
    check("t1_rresp", 32'(r), 32'(RESP_OKAY));
    check("t1_rd_pulse", 32'(p), 32'h04);
    check("t1_rd_latency", 32'(lat), 32'd0);

    // 2: W leads AW by three cycles, single-byte strobe
    do_write(6'h00, 32'h1122_3344, 4'hF, resp, p_at, p_after);
    check("t2_init", rv(0), 32'h1122_3344);
    send_w(32'h0000_AB00, 4'b0010);
    tick();
    tick();
    check("t2_no_commit", 32'(bvalid), 32'd0);
    check("t2_w_held", 32'(wready), 32'd0);
    send_aw(6'h00);
    wait_b(resp, p_at, p_after);
    check("t2_bresp", 32'(resp), 32'(RESP_OKAY));
    check("t2_wr_pulse", 32'(p_at), 32'h01);
    check("t2_reg0", rv(0), 32'h1122_AB44);

    // 3: write to RO and out-of-range registers, read out of range
    do_write(6'h04, 32'hFFFF_FFFF, 4'hF, resp, p_at, p_after);
    check("t3_ro_bresp", 32'(resp), 32'(RESP_SLVERR));
    check("t3_ro_no_pulse", 32'(p_at), 32'h00);
    do_write(6'h3C, 32'hFFFF_FFFF, 4'hF, resp, p_at, p_after);
    check("t3_oor_bresp", 32'(resp), 32'(RESP_SLVERR));
    check("t3_oor_no_pulse", 32'(p_at), 32'h00);
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
    exp_regs[0] = 32'h1122_AB44;
    exp_regs[1] = 32'hCAFE_0001;
    exp_regs[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < NR; i++) begin
      check($sformatf("t3_reg%0d", i), rv(i), exp_regs[i]);
    end
    do_read(6'h3C, d, r, p, lat);
    check("t3_oor_rdata", d, 32'h0);
    check("t3_oor_rresp", 32'(r), 32'(RESP_SLVERR));
    check("t3_oor_rd_pulse", 32'(p), 32'h00);

    // 4: B held off while a second write is captured; responses stay in order
    bready = 1'b0;
    fork
      send_aw(6'h3C);
      send_w(32'h4444_4444, 4'hF);
    join
    begin
      int n = 0;
      while (!bvalid && n < 20) begin
        tick();
        n++;
      end
    end
    fork
      send_aw(6'h14);
      send_w(32'h5555_5555, 4'hF);
    join
    repeat (3) tick();
    check("t4_bvalid_held", 32'(bvalid), 32'd1);
    check("t4_bresp_held", 32'(bresp), 32'(RESP_SLVERR));
    check("t4_aw_full", 32'(awready), 32'd0);
    check("t4_second_pending", rv(5), 32'h0);
    wait_b(resp, p_at, p_after);
    check("t4_first_bresp", 32'(resp), 32'(RESP_SLVERR));
    wait_b(resp, p_at, p_after);
    check("t4_second_bresp", 32'(resp), 32'(RESP_OKAY));
    check("t4_second_pulse", 32'(p_at), 32'h20);
    check("t4_reg5", rv(5), 32'h5555_5555);

    // 5: back-to-back reads, then RREADY low stalls the channel
    rready  = 1'b1;
    araddr  = 6'h00;
    arvalid = 1'b1;
    #1;
    check("t5_arready", 32'(arready), 32'd1);
    tick();
    check("t5_rvalid0", 32'(rvalid), 32'd1);
    check("t5_rdata0", rdata, 32'h1122_AB44);
    check("t5_rd_pulse0", 32'(rd_pulse), 32'h01);
    araddr = 6'h04;
    tick();
    check("t5_rdata1", rdata, 32'hCAFE_0001);
    check("t5_rresp1", 32'(rresp), 32'(RESP_OKAY));
    check("t5_rd_pulse1", 32'(rd_pulse), 32'h02);
    araddr = 6'h08;
    tick();
    check("t5_rvalid2", 32'(rvalid), 32'd1);
    check("t5_rdata2", rdata, 32'hDEAD_BEEF);
    rready = 1'b0;
    araddr = 6'h0C;
    #1;
    check("t5_arready_stall", 32'(arready), 32'd0);
    tick();
    tick();
    check("t5_rvalid_stall", 32'(rvalid), 32'd1);
    check("t5_rdata_stable", rdata, 32'hDEAD_BEEF);
    check("t5_no_rd_pulse", 32'(rd_pulse), 32'h00);
    rready = 1'b1;
    #1;
    check("t5_arready_resume", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    check("t5_rdata3", rdata, 32'h0);
    check("t5_rd_pulse3", 32'(rd_pulse), 32'h08);
    tick();
    check("t5_rvalid_drop", 32'(rvalid), 32'd0);
    rready = 1'b0;

    // 6: register 3 behaviour with and without the W1C option
`ifdef HSM_REGFILE_W1C_EN
    hw_set = 8'h08;
    tick();
    hw_set = 8'h00;
    tick();
    check("t6_hw_set", rv(3), 32'h1);
    hw_set = 8'h08;
    do_write(6'h0C, 32'h1, 4'hF, resp, p_at, p_after);
    hw_set = 8'h00;
    check("t6_set_wins", rv(3), 32'h1);
    do_write(6'h0C, 32'h1, 4'b1110, resp, p_at, p_after);
    check("t6_strobe_off", rv(3), 32'h1);
    do_write(6'h0C, 32'h1, 4'hF, resp, p_at, p_after);
    check("t6_bresp", 32'(resp), 32'(RESP_OKAY));
    check("t6_clear", rv(3), 32'h0);
`else
    hw_set = 8'h08;
    tick();
    hw_set = 8'h00;
    tick();
    check("t6_hw_set_ignored", rv(3), 32'h0);
    do_write(6'h0C, 32'h1, 4'hF, resp, p_at, p_after);
    check("t6_plain_write", rv(3), 32'h1);
    do_write(6'h0C, 32'h1, 4'hF, resp, p_at, p_after);
    check("t6_no_clear", rv(3), 32'h1);
    do_write(6'h0C, 32'h0, 4'b1110, resp, p_at, p_after);
    check("t6_strobe_off", rv(3), 32'h1);
`endif

    // Reset during a captured-but-uncommitted write
    fork
      send_aw(6'h18);
      send_w(32'h6666_6666, 4'hF);
    join
    rst_n = 1'b0;
    #1;
    check("rst_mid_bvalid", 32'(bvalid), 32'd0);
    check("rst_mid_awready", 32'(awready), 32'd0);
    check("rst_mid_reg0", rv(0), 32'h0);
    check("rst_mid_reg6", rv(6), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("rst_after_bvalid", 32'(bvalid), 32'd0);
    check("rst_after_reg6", rv(6), 32'h0);
    check("rst_after_awready", 32'(awready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
